frame_stream_tx: RTL and testbench
==================================

FRAME_STREAM_TX -- requirements
Module: frame_stream_tx

Interface
REQ-001 SHALL have parameter D, default 299, meaning the square frame edge in pixels; the frame holds T = D*D pixels.
REQ-002 SHALL have parameter data_width, default 32, meaning the pixel word width (IEEE-754 single).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins one frame.
REQ-006 SHALL have port hold, input, 1 bit: downstream stall request.
REQ-007 SHALL have port mem_rd_en, output, 1 bit: frame-memory read strobe.
REQ-008 SHALL have port mem_addr, output, AW = clog2(T) bits: frame-memory word address.
REQ-009 SHALL have port mem_rd_data, input, data_width bits: read data, valid exactly one cycle after mem_rd_en.
REQ-010 SHALL have port pxl_out, output, data_width bits: streamed pixel, the conv_31_p pxl_in source.
REQ-011 SHALL have port valid_out, output, 1 bit: pxl_out qualifier, the conv_31_p valid_in source.
REQ-012 SHALL have port sof / eol / eof, output, 1 bit each: first pixel of frame, last pixel of row, last pixel of frame; each is valid only with valid_out.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM IDLE -> STREAM -> DRAIN -> IDLE.
REQ-016 IDLE: start=1 SHALL move to STREAM, clear the address counter, and set busy at the next edge.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 STREAM: mem_rd_en SHALL be asserted with mem_addr = next address when hold=0 and the skid is empty; the address then increments by 1.
REQ-019 After issuing address T-1, the FSM SHALL go to DRAIN, with no further reads.
REQ-020 A read's data SHALL load pxl_out with valid_out=1 on the edge after mem_rd_en, provided hold=0 and the skid is empty.
REQ-021 Latency: start sampled at edge k SHALL give first mem_rd_en in cycle k+1 and first valid_out in cycle k+2, when there is no hold.
REQ-022 hold=1 SHALL freeze pxl_out, valid_out, sof, eol and eof, and SHALL suppress mem_rd_en.
REQ-023 Data returning while hold=1 (the read issued in the cycle hold rose) SHALL be captured in a 1-entry skid register.
REQ-024 On hold falling, the skid contents SHALL be output first; reads resume only once the skid is empty.
REQ-025 No pixel SHALL be dropped or duplicated under any hold pattern.
REQ-026 With hold=0 and no pending data, valid_out SHALL drop to 0 at the next edge.
REQ-027 Row and column counters (0..D-1) SHALL advance per emitted pixel, the column wrapping at D-1 and incrementing the row.
REQ-028 sof SHALL be asserted at (0,0), eol at col D-1, and eof at (D-1,D-1).
REQ-029 DRAIN: once the eof pixel has been emitted (valid_out=1, hold=0), the FSM SHALL go to IDLE, pulse done for 1 cycle, and clear busy.
REQ-030 Pixel order SHALL be row-major, address = row*D + col.
REQ-031 start arriving in the same cycle as done SHALL be ignored; a new start is accepted only from IDLE.
REQ-032 hold SHALL have no effect in IDLE.

Reset
REQ-033 reset=1 SHALL immediately force IDLE, clear counters and skid, and drive pxl_out=0, valid_out=0, sof=eol=eof=0, mem_rd_en=0, mem_addr=0, busy=0, done=0.
REQ-034 Reset during a frame SHALL abort it with no done pulse; the next frame restarts at address 0.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings and the clog2 address-width function, for reuse by the conv_*_p family.
REQ-036 The skid/output register SHALL be a single sub-module pxl_skid_1 (data_width parameter, in valid/hold, out valid/data); counters and the FSM stay in frame_stream_tx.

Verification
REQ-037 D=4, mem word i = i+1, hold=0, start at cycle 0 -> pxl_out 1..16 on consecutive cycles 2..17; sof@2, eol@5/9/13/17, eof@17; done@18.
REQ-038 D=4, hold=1 for cycles 4-6 -> pixel sequence unbroken (1..16), output frozen during the hold, last pixel at cycle 20.
REQ-039 hold toggling every cycle over the whole frame -> exactly 16 valid, non-held transfers in order with no duplicates.
REQ-040 reset asserted at cycle 8 mid-frame -> all outputs 0 asynchronously with no done pulse; a restart then emits 1..16 from address 0.
REQ-041 start pulsed while busy, and in the done cycle -> ignored, so exactly one frame is emitted.
REQ-042 D=299 full frame with conv_31_p downstream -> 89401 valid pixels and a single done; the output file matches the golden convolution.

Source files
------------

// File: rtl/frame_stream_tx_pkg.sv
// Shared definitions for the frame streaming / convolution block family:
// controller state encodings and the address-width helper.
package frame_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } tx_state_t;

    // Ceiling log2 of a word count, never less than one bit.
    function automatic int clog2_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_stream_tx_if.sv
// Frame-memory read port: registered strobe and address out, read word back.
interface frame_stream_tx_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;

    modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/pxl_skid_1.sv
// Output register with a single skid entry: catches the one word still in
// flight when hold rises and replays it ahead of anything else.
module pxl_skid_1 #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    input  logic                  hold,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic                  skid_valid
);
    logic                  out_valid_reg;
    logic [data_width-1:0] out_data_reg;
    logic                  skid_valid_reg;
    logic [data_width-1:0] skid_data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else if (hold) begin
            if (in_valid && !skid_valid_reg) begin
                skid_data_reg  <= in_data;
                skid_valid_reg <= 1'b1;
            end
        end else if (skid_valid_reg) begin
            out_data_reg   <= skid_data_reg;
            out_valid_reg  <= 1'b1;
            skid_valid_reg <= 1'b0;
        end else if (in_valid) begin
            out_data_reg  <= in_data;
            out_valid_reg <= 1'b1;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign skid_valid = skid_valid_reg;

endmodule

// File: rtl/frame_stream_tx.sv
// Streams a D x D frame out of a word memory in row-major order with
// sof/eol/eof markers, honouring a downstream hold without losing pixels.
module frame_stream_tx
    import frame_stream_tx_pkg::*;
#(
    parameter int D          = 299,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  hold,
    frame_stream_tx_if.master     mem,
    output logic [data_width-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done
);
    localparam int T  = D * D;
    localparam int AW = clog2_width(T);
    localparam int CW = clog2_width(D);
    localparam logic [AW-1:0] LAST_ADDR = AW'(T - 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(D - 1);

    tx_state_t     state_reg;
    logic          rd_en_reg;
    logic [AW-1:0] addr_reg;
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic          sof_reg;
    logic          eol_reg;
    logic          eof_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          skid_valid;
    logic          emit;

    // A word reaches the output register on every non-held edge that has
    // either a returning read or a parked skid word.
    assign emit = !hold && (rd_en_reg || skid_valid);

    pxl_skid_1 #(
        .data_width(data_width)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en_reg),
        .in_data   (mem.mem_rd_data),
        .hold      (hold),
        .out_valid (valid_out),
        .out_data  (pxl_out),
        .skid_valid(skid_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            rd_en_reg <= 1'b0;
            addr_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            sof_reg   <= 1'b0;
            eol_reg   <= 1'b0;
            eof_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (emit) begin
                sof_reg <= (row_reg == '0) && (col_reg == '0);
                eol_reg <= (col_reg == LAST_IDX);
                eof_reg <= (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
                if (col_reg == LAST_IDX) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end else if (!hold) begin
                sof_reg <= 1'b0;
                eol_reg <= 1'b0;
                eof_reg <= 1'b0;
            end

            unique case (state_reg)
                ST_IDLE: begin
                    rd_en_reg <= 1'b0;
                    // The done cycle is still IDLE; a start there is refused.
                    if (start && !done_reg) begin
                        state_reg <= ST_STREAM;
                        busy_reg  <= 1'b1;
                        rd_en_reg <= 1'b1;
                        addr_reg  <= '0;
                        row_reg   <= '0;
                        col_reg   <= '0;
                    end
                end
                ST_STREAM: begin
                    // A non-held edge always drains the skid, so it is free
                    // for the word this read returns.
                    if (hold) begin
                        rd_en_reg <= 1'b0;
                    end else begin
                        rd_en_reg <= 1'b1;
                        addr_reg  <= addr_reg + 1'b1;
                        if (addr_reg == LAST_ADDR - 1'b1) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    rd_en_reg <= 1'b0;
                    if (valid_out && eof_reg && !hold) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_rd_en = rd_en_reg;
    assign mem.mem_addr  = addr_reg;
    assign sof           = sof_reg;
    assign eol           = eol_reg;
    assign eof           = eof_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx at D=4: table of hold scenarios checked against
// a pixel scoreboard, plus a mid-frame reset sequence.
module tb_frame_stream_tx;
    import frame_stream_tx_pkg::*;

    localparam int D      = 4;
    localparam int T      = D * D;
    localparam int AW     = clog2_width(T);
    localparam int BUDGET = 150;

    typedef struct {
        int mode;      // 0 none, 1 window lo..hi, 2 toggle, 3 random
        int lo;
        int hi;
        int extra;     // extra start pulses while busy and in the done cycle
        int first;     // expected cycle of first transfer, -1 = unchecked
        int last;
        int donec;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    logic clk;
    logic reset;
    logic start;
    logic hold;
    logic [31:0] pxl_out;
    logic valid_out, sof, eol, eof, busy, done;

    int n_checks;
    int n_fail;
    exp_t sb[$];
    vec_t vecs[5];

    frame_stream_tx_if #(.AW(AW), .DW(32)) mem_if ();

    // Zero-wait frame memory: word i holds i+1, sampled on the edge closing
    // the read cycle; anything read without a strobe is poisoned.
    assign mem_if.mem_rd_data = mem_if.mem_rd_en ? (32'(mem_if.mem_addr) + 32'd1) : 32'hDEAD_BEEF;

    frame_stream_tx #(.D(D), .data_width(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hold     (hold),
        .mem      (mem_if.master),
        .pxl_out  (pxl_out),
        .valid_out(valid_out),
        .sof      (sof),
        .eol      (eol),
        .eof      (eof),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({pxl_out, valid_out, sof, eol, eof, mem_if.mem_rd_en, mem_if.mem_addr, busy, done});
    endfunction

    task automatic run_frame(input vec_t v, input int idx);
        int first_c, last_c, done_c, n_done, n_xfer, after, c;
        logic prev_hold;
        logic [63:0] prev_out;
        exp_t e;
        first_c = -1; last_c = -1; done_c = -1;
        n_done = 0; n_xfer = 0; after = 0; c = 0;
        prev_hold = 1'b0; prev_out = '0;
        for (int i = 0; i < T; i++) begin
            e.data = 32'(i + 1);
            e.sof  = (i == 0);
            e.eol  = ((i % D) == D - 1);
            e.eof  = (i == T - 1);
            sb.push_back(e);
        end
        while (c < BUDGET && !(n_done > 0 && after >= 6)) begin
            @(posedge clk); #1;
            start = (c == 0) || ((v.extra != 0) && (c == 5 || done == 1'b1));
            case (v.mode)
                1:       hold = (c >= v.lo) && (c <= v.hi);
                2:       hold = (c % 2) == 1;
                3:       hold = (c >= 1) && ($urandom_range(1) == 1);
                default: hold = 1'b0;
            endcase
            @(negedge clk);
            if (prev_hold)
                check("frozen_under_hold", 64'({pxl_out, valid_out, sof, eol, eof}), prev_out);
            if (c == 1)
                check("first_read_addr0", 64'({mem_if.mem_rd_en, busy, mem_if.mem_addr}), 64'({1'b1, 1'b1, AW'(0)}));
            if (valid_out && !hold) begin
                if (sb.size() == 0) begin
                    check("extra_pixel", 64'(pxl_out), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("pixel", 64'({pxl_out, sof, eol, eof}), 64'({e.data, e.sof, e.eol, e.eof}));
                end
                $display("frame %0d cycle %0d pixel %0d sof %0b eol %0b eof %0b", idx, c, pxl_out, sof, eol, eof);
                if (first_c < 0) first_c = c;
                last_c = c;
                n_xfer++;
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (n_done > 0) after++;
            prev_hold = hold;
            prev_out  = 64'({pxl_out, valid_out, sof, eol, eof});
            c++;
        end
        start = 1'b0;
        hold  = 1'b0;
        check("done_count", 64'(n_done), 64'd1);
        check("transfer_count", 64'(n_xfer), 64'(T));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("idle_after_frame", 64'({busy, valid_out}), 64'd0);
        if (v.first >= 0) begin
            check("first_cycle", 64'(first_c), 64'(v.first));
            check("last_cycle", 64'(last_c), 64'(v.last));
            check("done_cycle", 64'(done_c), 64'(v.donec));
        end
        sb.delete();
    endtask

    initial begin
        int aborted_done;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{mode: 0, lo: 0, hi: 0, extra: 0, first: 2, last: 17, donec: 18};
        vecs[1] = '{mode: 1, lo: 4, hi: 6, extra: 0, first: 2, last: 20, donec: 21};
        vecs[2] = '{mode: 2, lo: 0, hi: 0, extra: 0, first: -1, last: -1, donec: -1};
        vecs[3] = '{mode: 0, lo: 0, hi: 0, extra: 1, first: 2, last: 17, donec: 18};
        vecs[4] = '{mode: 1, lo: 0, hi: 0, extra: 0, first: 2, last: 17, donec: 18};

        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs_vec(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        run_frame('{mode: 3, lo: 0, hi: 0, extra: 0, first: -1, last: -1, donec: -1}, 5);

        // Mid-frame abort: reset lands partway through cycle 8.
        aborted_done = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            if (done) aborted_done++;
            @(posedge clk);
        end
        #3;
        reset = 1'b1;
        #1;
        check("reset_async", outs_vec(), 64'd0);
        repeat (2) begin
            @(negedge clk);
            if (done) aborted_done++;
        end
        check("abort_no_done", 64'(aborted_done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", outs_vec(), 64'd0);
        run_frame(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
